// File: rtl/mpx_cfg_regs.sv
// mpx_cfg_regs: APB register file for the multi-channel MPX encoder (double-buffered gain/step, ROM loader, stat snapshots)
module mpx_cfg_regs #(
    parameter int NCH    = 2,
    parameter int ROM_AW = 10,
    parameter int ROM_DW = 8,
    parameter int STAT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  sample_stb,
    output logic [NCH*32-1:0]     pilot_gain,
    output logic [NCH*32-1:0]     step,
    output logic                  cfg_update,
    output logic [ROM_AW-1:0]     rom_addr,
    output logic [ROM_DW-1:0]     rom_data,
    output logic                  rom_wr_en,
    output logic [NCH*2-1:0]      stat_cfg,
    output logic [NCH*32-1:0]     stat_limit,
    output logic [NCH-1:0]        stat_clr,
    input  logic [NCH*STAT_W-1:0] stat_min,
    input  logic [NCH*STAT_W-1:0] stat_max,
    input  logic [NCH*32-1:0]     stat_count
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]        state;
    logic [ROM_AW-1:0] ptr;
    logic [31:0]       snap_cnt;
    logic [31:0]       gain_sh    [NCH];
    logic [31:0]       step_sh    [NCH];
    logic [STAT_W-1:0] snap_min   [NCH];
    logic [STAT_W-1:0] snap_max   [NCH];
    logic [31:0]       snap_count [NCH];
    logic [NCH-1:0]    cw;
    logic [31:0]       rd;
    logic [5:0]        word;
    logic [6:0]        cidx;
    logic [2:0]        off;
    logic access, wr, glob, ch_ok, mapped, ctrl_wr, force_wr, set_wr, stb_commit, commit;
    logic unused;

    assign unused     = ^{paddr[31:12], paddr[1:0]};
    assign access     = psel && penable;
    assign word       = paddr[7:2];
    assign off        = paddr[4:2];
    assign cidx       = paddr[11:5] - 7'd8;
    // Channel space starts at 0x100, so the global page and channel page never overlap.
    assign glob       = (paddr[11:8] == 4'd0) && (word <= 6'd4);
    assign ch_ok      = (paddr[11:5] >= 7'd8) && (cidx < 7'(NCH));
    assign mapped     = glob || ch_ok;
    assign pready     = access;
    assign pslverr    = access && !mapped;
    assign wr         = access && pwrite && mapped;
    assign ctrl_wr    = wr && glob && (word == 6'd0);
    assign force_wr   = ctrl_wr && pwdata[1];
    assign set_wr     = ctrl_wr && pwdata[0];
    assign stb_commit = (state == PENDING) && sample_stb;
    assign commit     = force_wr || stb_commit;
    assign prdata     = rd;

    // Per-channel write strobes and combinational read mux (unmapped addresses read 0).
    always_comb begin
        cw = '0;
        rd = '0;
        for (int c = 0; c < NCH; c++)
            cw[c] = wr && ch_ok && (cidx == 7'(c));
        if (glob)
            case (word)
                6'd0:    rd = {31'b0, state};
                6'd1:    rd = 32'(ptr);
                6'd3:    rd = snap_cnt;
                6'd4:    rd = {8'(NCH), 8'(ROM_AW), 16'h4D50};
                default: rd = '0;
            endcase
        else if (ch_ok)
            for (int c = 0; c < NCH; c++)
                if (cidx == 7'(c))
                    case (off)
                        3'd0:    rd = gain_sh[c];
                        3'd1:    rd = step_sh[c];
                        3'd2:    rd = 32'(stat_cfg[c*2+:2]);
                        3'd3:    rd = stat_limit[c*32+:32];
                        3'd4:    rd = 32'(snap_min[c]);
                        3'd5:    rd = 32'(snap_max[c]);
                        3'd6:    rd = snap_count[c];
                        default: rd = '0;
                    endcase
    end

    // Commit FSM: a forced commit wins over a new request; a request made on a strobe cycle waits for the next strobe.
    always_ff @(posedge clk)
        if (reset) begin
            state      <= IDLE;
            cfg_update <= 1'b0;
        end else begin
            state      <= force_wr ? IDLE : set_wr ? PENDING : stb_commit ? IDLE : state;
            cfg_update <= commit;
        end

    // Shadow/live gain and step, direct stat config, and clear pulses; live takes the pre-write shadow on a commit.
    always_ff @(posedge clk)
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                gain_sh[c]             <= 32'h256;
                step_sh[c]             <= '0;
                pilot_gain[c*32+:32]   <= 32'h256;
                step[c*32+:32]         <= '0;
                stat_cfg[c*2+:2]       <= 2'b01;
                stat_limit[c*32+:32]   <= '0;
                stat_clr[c]            <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (commit) begin
                    pilot_gain[c*32+:32] <= gain_sh[c];
                    step[c*32+:32]       <= step_sh[c];
                end
                if (cw[c] && off == 3'd0) gain_sh[c] <= pwdata;
                if (cw[c] && off == 3'd1) step_sh[c] <= pwdata;
                if (cw[c] && off == 3'd2) stat_cfg[c*2+:2] <= pwdata[1:0];
                if (cw[c] && off == 3'd3) stat_limit[c*32+:32] <= pwdata;
                stat_clr[c] <= cw[c] && off == 3'd7 && pwdata[0];
            end
        end

    // Auto-incrementing ROM loader: each data write emits one strobe and advances the pointer.
    always_ff @(posedge clk)
        if (reset) begin
            ptr       <= '0;
            rom_addr  <= '0;
            rom_data  <= '0;
            rom_wr_en <= 1'b0;
        end else begin
            rom_wr_en <= wr && glob && word == 6'd2;
            if (wr && glob && word == 6'd1) ptr <= pwdata[ROM_AW-1:0];
            if (wr && glob && word == 6'd2) begin
                rom_addr <= ptr;
                rom_data <= pwdata[ROM_DW-1:0];
                ptr      <= ptr + 1'b1;
            end
        end

    // Coherent snapshot of every channel's statistics on a single edge.
    always_ff @(posedge clk)
        if (reset) begin
            snap_cnt <= '0;
            for (int c = 0; c < NCH; c++) begin
                snap_min[c]   <= '0;
                snap_max[c]   <= '0;
                snap_count[c] <= '0;
            end
        end else if (wr && glob && word == 6'd3) begin
            snap_cnt <= snap_cnt + 1'b1;
            for (int c = 0; c < NCH; c++) begin
                snap_min[c]   <= stat_min[c*STAT_W+:STAT_W];
                snap_max[c]   <= stat_max[c*STAT_W+:STAT_W];
                snap_count[c] <= stat_count[c*32+:32];
            end
        end
endmodule
